// File: rtl/clk_reset_seq.sv
// clk_reset_seq: PLL-lock driven reset sequencer and clock-enable divider
// for the Spectrum core. Waits for a stable lock of LOCK_HOLD cycles before
// releasing core_reset, then generates the 7 MHz / 3.5 MHz enables from a
// 56 MHz clock.
//
// Optional feature: define CLK_RESET_SEQ_TURBO_EN to add the `turbo` input,
// which selects ce_7m instead of ce_3m5 as the CPU enable. The mode switch
// only takes effect at a 16-cycle period boundary.
//
// state     | meaning
// WAIT_LOCK | PLL not locked, core held in reset
// HOLD      | lock seen, counting LOCK_HOLD stable cycles
// RUN       | core released, clock enables running
module clk_reset_seq #(
  parameter int unsigned LOCK_HOLD = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       reset_req,
`ifdef CLK_RESET_SEQ_TURBO_EN
  input  logic       turbo,
`endif
  output logic       core_reset,
  output logic       ready,
  output logic       ce_7m,
  output logic       ce_3m5,
  output logic       ce_3m5_n,
  output logic       ce_cpu,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(LOCK_HOLD - 1);

  state_t      state;
  state_t      state_nx;
  logic        sync_1;
  logic        lk;
  logic [15:0] hc;
  logic [3:0]  div;
  logic        run_now;
  logic        stay_run;

  assign run_now  = (state == RUN);
  // Enables are only produced when RUN continues into the next cycle, so a
  // lock loss or soft reset never leaves a stray pulse behind.
  assign stay_run = run_now && (state_nx == RUN);

  // Next-state decode; lk=0 outranks a soft-reset request.
  always_comb begin
    state_nx = state;
    case (state)
      WAIT_LOCK: if (lk) state_nx = HOLD;
      HOLD: begin
        if (!lk)                  state_nx = WAIT_LOCK;
        else if (hc == HOLD_LAST) state_nx = RUN;
      end
      RUN: begin
        if (!lk)            state_nx = WAIT_LOCK;
        else if (reset_req) state_nx = HOLD;
      end
      default: state_nx = WAIT_LOCK;
    endcase
  end

  // Lock synchronizer, sequencer state, divider and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1        <= 1'b0;
      lk            <= 1'b0;
      state         <= WAIT_LOCK;
      hc            <= '0;
      div           <= '0;
      core_reset    <= 1'b1;
      ready         <= 1'b0;
      ce_7m         <= 1'b0;
      ce_3m5        <= 1'b0;
      ce_3m5_n      <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      sync_1     <= pll_locked;
      lk         <= sync_1;
      state      <= state_nx;
      hc         <= (state == HOLD && state_nx == HOLD) ? hc + 16'd1 : 16'd0;
      div        <= stay_run ? div + 4'd1 : 4'd0;
      core_reset <= !run_now;
      ready      <= run_now;
      ce_7m      <= stay_run && (div[2:0] == 3'd7);
      ce_3m5     <= stay_run && (div == 4'd15);
      ce_3m5_n   <= stay_run && (div == 4'd7);
      if (run_now && !lk && lock_loss_cnt != 8'hFF)
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

`ifdef CLK_RESET_SEQ_TURBO_EN
  logic turbo_q;

  // Mode latch only moves at a period boundary so a CPU period is never cut.
  always_ff @(posedge clk) begin
    if (rst)                       turbo_q <= 1'b0;
    else if (!run_now || div == 4'd15) turbo_q <= turbo;
  end

  assign ce_cpu = turbo_q ? ce_7m : ce_3m5;
`else
  assign ce_cpu = ce_3m5;
`endif

endmodule

// File: tb/tb_clk_reset_seq.sv
// Bench for clk_reset_seq (LOCK_HOLD=16): a cycle model predicts every
// output vector, which is queued when stimulus is driven and compared when
// the DUT has clocked it. Directed latency/count checks sit on top.
module tb_clk_reset_seq;
  localparam int LH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       reset_req = 1'b0;
  logic       tb_turbo = 1'b0;
  logic       core_reset, ready, ce_7m, ce_3m5, ce_3m5_n, ce_cpu;
  logic [7:0] lock_loss_cnt;

  clk_reset_seq #(.LOCK_HOLD(LH)) dut (
    .clk(clk),
    .rst(rst),
    .pll_locked(pll_locked),
    .reset_req(reset_req),
`ifdef CLK_RESET_SEQ_TURBO_EN
    .turbo(tb_turbo),
`endif
    .core_reset(core_reset),
    .ready(ready),
    .ce_7m(ce_7m),
    .ce_3m5(ce_3m5),
    .ce_3m5_n(ce_3m5_n),
    .ce_cpu(ce_cpu),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ovl = 0;
  int ce_in_rst = 0;
  int cyc = 0;
  int last_cpu = -1;
  int min_gap = 1000;

  logic [13:0] exp_q[$];

  // model state
  bit m_s1, m_lk, m_cr, m_rdy, m_c7, m_c35, m_c35n, m_tq;
  int m_st, m_hc, m_div, m_llc;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // states: 0 wait, 1 hold, 2 run
  task automatic model_step(input bit r, input bit p, input bit q, input bit t);
    int  nst;
    bit  run0;
    if (r) begin
      m_s1 = 0; m_lk = 0; m_st = 0; m_hc = 0; m_div = 0; m_cr = 1; m_rdy = 0;
      m_c7 = 0; m_c35 = 0; m_c35n = 0; m_llc = 0; m_tq = 0;
      return;
    end
    run0 = (m_st == 2);
    nst  = m_st;
    case (m_st)
      0: if (m_lk) nst = 1;
      1: if (!m_lk) nst = 0; else if (m_hc == LH - 1) nst = 2;
      default: if (!m_lk) nst = 0; else if (q) nst = 1;
    endcase
    m_c7   = run0 && nst == 2 && (m_div % 8 == 7);
    m_c35  = run0 && nst == 2 && (m_div == 15);
    m_c35n = run0 && nst == 2 && (m_div == 7);
    m_cr   = !run0;
    m_rdy  = run0;
    if (run0 && !m_lk && m_llc < 255) m_llc++;
    if (!run0 || m_div == 15) m_tq = t;
    m_div = (run0 && nst == 2) ? (m_div + 1) % 16 : 0;
    m_hc  = (m_st == 1 && nst == 1) ? m_hc + 1 : 0;
    m_st  = nst;
    m_lk  = m_s1;
    m_s1  = p;
  endtask

  task automatic tick(input bit r, input bit p, input bit q);
    logic [13:0] e, o;
    bit cpu;
    model_step(r, p, q, tb_turbo);
`ifdef CLK_RESET_SEQ_TURBO_EN
    cpu = m_tq ? m_c7 : m_c35;
`else
    cpu = m_c35;
`endif
    exp_q.push_back({cpu, m_c35n, m_c35, m_c7, m_rdy, m_cr, 8'(m_llc)});
    rst = r; pll_locked = p; reset_req = q;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    o = {ce_cpu, ce_3m5_n, ce_3m5, ce_7m, ready, core_reset, lock_loss_cnt};
    e = exp_q.pop_front();
    chk("cycle", 16'(o), 16'(e));
    if (ce_3m5 && ce_3m5_n) ovl++;
    if (core_reset && (ce_7m || ce_3m5 || ce_3m5_n || ce_cpu)) ce_in_rst++;
    if (ce_cpu === 1'b1) begin
      if (last_cpu >= 0 && cyc - last_cpu < min_gap) min_gap = cyc - last_cpu;
      last_cpu = cyc;
    end
  endtask

  // Ticks with pll high until core_reset drops; n = ticks taken (60 = timeout).
  task automatic run_until_ready(output int n);
    n = 0;
    while (core_reset !== 1'b0 && n < 60) begin
      tick(0, 1, 0);
      n++;
    end
  endtask

  int n, n7, n35, n35n, hi;

  initial begin
    // reset state
    repeat (4) tick(1, 0, 0);
    chk("rst_core_reset", 16'(core_reset), 16'd1);
    chk("rst_ready", 16'(ready), 16'd0);
    chk("rst_llc", 16'(lock_loss_cnt), 16'd0);

    // startup latency: 2 sync + 1 wait + 16 hold
    run_until_ready(n);
    chk("lock_latency", 16'(n - 1), 16'd19);
    chk("ready_with_release", 16'(ready), 16'd1);

    // enables over 64 run cycles
    n7 = 0; n35 = 0; n35n = 0;
    repeat (64) begin
      tick(0, 1, 0);
      n7 += int'(ce_7m); n35 += int'(ce_3m5); n35n += int'(ce_3m5_n);
    end
    chk("ce_7m_count", 16'(n7), 16'd8);
    chk("ce_3m5_count", 16'(n35), 16'd4);
    chk("ce_3m5_n_count", 16'(n35n), 16'd4);

    // soft reset: core_reset high for exactly the hold time
    tick(0, 1, 1);
    hi = 0;
    repeat (24) begin
      tick(0, 1, 0);
      hi += int'(core_reset);
    end
    chk("soft_reset_width", 16'(hi), 16'd16);
    chk("soft_reset_llc", 16'(lock_loss_cnt), 16'd0);

    // reset_req in the cycle lk falls: lock loss wins
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 1);
    repeat (24) tick(0, 0, 0);
    chk("req_vs_loss_state", 16'(core_reset), 16'd1);
    chk("req_vs_loss_llc", 16'(lock_loss_cnt), 16'd1);

    // glitch during hold at hc=10
    repeat (2) tick(1, 0, 0);
    chk("rst_mid_llc", 16'(lock_loss_cnt), 16'd0);
    repeat (13) tick(0, 1, 0);
    repeat (3) tick(0, 0, 0);
    chk("glitch_in_reset", 16'(core_reset), 16'd1);
    run_until_ready(n);
    chk("glitch_relock_latency", 16'(n - 1), 16'd19);
    chk("glitch_llc", 16'(lock_loss_cnt), 16'd0);

`ifdef CLK_RESET_SEQ_TURBO_EN
    repeat (21) tick(0, 1, 0);
    last_cpu = -1; min_gap = 1000;
    repeat (37) tick(0, 1, 0);
    tb_turbo = 1'b1;
    repeat (67) tick(0, 1, 0);
    tb_turbo = 1'b0;
    repeat (64) tick(0, 1, 0);
    chk("turbo_min_gap", 16'(min_gap), 16'd8);
    tb_turbo = 1'b0;
`endif

    // repeated lock loss, counter saturates at 255
    repeat (300) begin
      n = 0;
      while (core_reset !== 1'b1 && n < 10) begin
        tick(0, 0, 0);
        n++;
      end
      chk("loss_latency", 16'(n <= 4), 16'd1);
      tick(0, 0, 0);
      run_until_ready(n);
      chk("relock", 16'(core_reset), 16'd0);
    end
    chk("llc_saturated", 16'(lock_loss_cnt), 16'd255);
    tick(1, 1, 0);
    chk("llc_after_rst", 16'(lock_loss_cnt), 16'd0);
    chk("core_reset_after_rst", 16'(core_reset), 16'd1);

    chk("ce_overlap", 16'(ovl), 16'd0);
    chk("ce_during_reset", 16'(ce_in_rst), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/clk_reset_seq.md
CLK_RESET_SEQ -- requirements
Module: clk_reset_seq

Interface
REQ-001 SHALL have parameter LOCK_HOLD, default 1024, meaning the number of consecutive locked cycles required before the core is released (range 2..65535).
REQ-002 SHALL have port clk  input  1  PLL 56 MHz output clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port pll_locked  input  1  PLL locked flag, asynchronous to clk.
REQ-005 SHALL have port reset_req  input  1  single-cycle host soft-reset request.
REQ-006 SHALL have port core_reset  output  1  active-high reset to the Spectrum core.
REQ-007 SHALL have port ready  output  1  high only in state RUN.
REQ-008 SHALL have port ce_7m  output  1  pixel clock enable, 1 cycle in 8.
REQ-009 SHALL have port ce_3m5  output  1  CPU rising enable, 1 cycle in 16.
REQ-010 SHALL have port ce_3m5_n  output  1  CPU falling enable, 1 cycle in 16, 8 cycles offset from ce_3m5.
REQ-011 SHALL have port ce_cpu  output  1  selected CPU enable.
REQ-012 SHALL have port lock_loss_cnt  output  8  saturating count of lock losses while in RUN.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer to give lk; only lk is used internally.
REQ-014 SHALL implement states WAIT_LOCK, HOLD and RUN, plus a 16-bit hold counter hc.
REQ-015 In WAIT_LOCK: when lk=1, SHALL go to HOLD with hc=0.
REQ-016 In HOLD: when lk=0, SHALL go to WAIT_LOCK; when hc=LOCK_HOLD-1, SHALL go to RUN; otherwise hc increments by 1.
REQ-017 In RUN: when lk=0, SHALL go to WAIT_LOCK and increment lock_loss_cnt, saturating at 255.
REQ-018 In RUN: when lk=1 and reset_req=1, SHALL go to HOLD with hc=0; lock_loss_cnt is unchanged.
REQ-019 SHALL treat reset_req as a don't-care outside RUN, and SHALL give lk=0 priority over reset_req.
REQ-020 SHALL register core_reset as the inverse of "state is RUN", so it deasserts on the first RUN cycle and asserts on the first cycle after leaving RUN.
REQ-021 SHALL register ready to equal the inverse of core_reset.
REQ-022 SHALL hold a 4-bit divider div at 0 outside RUN; in RUN it increments by 1 each cycle, wrapping 15->0.
REQ-023 SHALL start div at 0 on the first RUN cycle.
REQ-024 SHALL register ce_7m as div[2:0]=7, ce_3m5 as div=15, and ce_3m5_n as div=7, all qualified by RUN.
REQ-025 SHALL drive all ce outputs to 0 outside RUN, so no enable pulse is emitted in any cycle where core_reset=1.
REQ-026 SHALL make the first ce_7m pulse appear 8 cycles after entering RUN and the first ce_3m5 pulse appear 16 cycles after entering RUN.
REQ-027 Lock-loss boundary: on a lock-loss transition, ce outputs SHALL be 0 from the next cycle and div SHALL be cleared.

Reset
REQ-028 With rst=1, on the next edge the block SHALL enter WAIT_LOCK with hc=0, div=0, both synchronizer flops 0, core_reset=1, ready=0, all ce outputs 0 and lock_loss_cnt=0.
REQ-029 Asserting rst mid-operation in any state SHALL have the same effect as REQ-028; rst SHALL take priority over every other input.

Configuration
REQ-030 Macro CLK_RESET_SEQ_TURBO_EN SHALL control the turbo feature.
REQ-031 With CLK_RESET_SEQ_TURBO_EN defined, the block SHALL add input turbo (1 bit).
REQ-032 With CLK_RESET_SEQ_TURBO_EN defined, a registered turbo_q SHALL sample turbo only when div=15 or outside RUN.
REQ-033 With CLK_RESET_SEQ_TURBO_EN defined, ce_cpu SHALL equal ce_7m when turbo_q=1 and ce_3m5 otherwise, so mode changes never shorten a CPU period.
REQ-034 With CLK_RESET_SEQ_TURBO_EN defined, turbo_q SHALL reset to 0.
REQ-035 Without CLK_RESET_SEQ_TURBO_EN, the turbo port SHALL be absent and ce_cpu SHALL equal ce_3m5.

Verification (LOCK_HOLD=16)
REQ-036 Startup: rst high 4 cycles, then pll_locked=1 -> core_reset falls exactly 2+1+16 cycles after the first sampling edge of locked=1, and ready rises in the same cycle.
REQ-037 Clock enables: run 64 cycles in RUN -> ce_7m count = 8, ce_3m5 = 4, ce_3m5_n = 4; ce_3m5 and ce_3m5_n are never high together; no pulse occurs while core_reset=1.
REQ-038 Glitch in HOLD: pll_locked low for 3 cycles at hc=10 -> state returns to WAIT_LOCK, the full 16-cycle hold restarts, and lock_loss_cnt stays 0.
REQ-039 Lock loss in RUN, repeated 300 times -> core_reset reasserts within 3 cycles of each pll_locked fall; lock_loss_cnt ends at 255; then rst=1 -> lock_loss_cnt=0.
REQ-040 Soft reset and priority: reset_req pulse in RUN -> core_reset high for 16 cycles then low; reset_req in the same cycle as lk falling -> WAIT_LOCK and lock_loss_cnt+1.
REQ-041 Turbo (macro defined): toggle turbo mid-period -> ce_cpu switches only after a div=15 cycle; CPU enable spacing is 16 then 8 cycles, never less than 8.
